// File: rtl/conv_window_fetch.sv
// conv_window_fetch: streams 3x3 convolution windows out of a tile held in SRAM.
// For every output position (row-major, stride 1, no padding) it issues nine SRAM
// reads, taps in row-major order, and presents the returned words on a
// valid/ready stream. A 2-entry FIFO absorbs the one-cycle SRAM read latency.
// Reads are throttled on FIFO space, so a stalled consumer never loses a word.
//
// Ports:
//   CLK, RST                - clock and synchronous active-high reset
//   Start, Tile_W, Tile_H   - frame start pulse and tile size (latched on Start)
//   SRAM_CSn/WEn/Addr/Q     - read-only SRAM port, data returns one cycle later
//   Win_Data/Tap/Last       - current window tap word, tap index, last-tap flag
//   Win_Valid, Win_Ready    - stream handshake
//   Busy, Frame_Done        - frame in progress, one-cycle end-of-frame pulse
module conv_window_fetch #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [6:0]        Tile_W,
  input  logic [6:0]        Tile_H,
  output logic              SRAM_CSn,
  output logic [3:0]        SRAM_WEn,
  output logic [ADDR_W-1:0] SRAM_Addr,
  input  logic [DATA_W-1:0] SRAM_Q,
  output logic [DATA_W-1:0] Win_Data,
  output logic [3:0]        Win_Tap,
  output logic              Win_Last,
  output logic              Win_Valid,
  input  logic              Win_Ready,
  output logic              Busy,
  output logic              Frame_Done
);

  // FIFO entry layout: {frame_end, tap[3:0], data}
  localparam int unsigned EntW = DATA_W + 5;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [6:0]        tile_w_q, tile_w_d;
  logic [6:0]        tile_h_q, tile_h_d;
  logic [6:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [1:0]        ky_q, ky_d;
  logic [1:0]        kx_q, kx_d;
  logic              rd_pend_q, rd_pend_d;
  logic [3:0]        rd_tap_q, rd_tap_d;
  logic              rd_end_q, rd_end_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [EntW-1:0]   ent0_q, ent0_d;
  logic [EntW-1:0]   ent1_q, ent1_d;

  logic              pop;
  logic              push;
  logic [1:0]        slots_used;
  logic              issue;
  logic [6:0]        row_sum;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        tap_idx;
  logic              last_tap;
  logic              last_col;
  logic              last_row;
  logic              last_read;
  logic [EntW-1:0]   new_ent;

  always_comb begin
    pop        = (fifo_cnt_q != 2'd0) && Win_Ready;
    push       = rd_pend_q;
    // The entry leaving this cycle counts as free, otherwise steady-state
    // streaming would stall every other cycle.
    slots_used = fifo_cnt_q - {1'b0, pop} + {1'b0, rd_pend_q};
    issue      = (state_q == StRun) && !RST && (slots_used < 2'd2);
    row_sum    = row_q + {5'd0, ky_q};
    rd_addr    = ADDR_W'(row_sum) * ADDR_W'(tile_w_q) + ADDR_W'(col_q) + ADDR_W'(kx_q);
    tap_idx    = 4'(ky_q) * 4'd3 + 4'(kx_q);
    last_tap   = (ky_q == 2'd2) && (kx_q == 2'd2);
    last_col   = (col_q == tile_w_q - 7'd3);
    last_row   = (row_q == tile_h_q - 7'd3);
    last_read  = last_tap && last_col && last_row;
    new_ent    = {rd_end_q, rd_tap_q, SRAM_Q};
  end

  always_comb begin
    state_d    = state_q;
    tile_w_d   = tile_w_q;
    tile_h_d   = tile_h_q;
    row_d      = row_q;
    col_d      = col_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    rd_pend_d  = issue;
    rd_tap_d   = tap_idx;
    rd_end_d   = issue && last_read;
    fifo_cnt_d = fifo_cnt_q;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;

    // Read-order counters: kx innermost, then ky, then column, then row.
    if (issue) begin
      if (kx_q == 2'd2) begin
        kx_d = 2'd0;
        if (ky_q == 2'd2) begin
          ky_d = 2'd0;
          if (last_col) begin
            col_d = 7'd0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          ky_d = ky_q + 2'd1;
        end
      end else begin
        kx_d = kx_q + 2'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          tile_w_d = Tile_W;
          tile_h_d = Tile_H;
          row_d    = 7'd0;
          col_d    = 7'd0;
          ky_d     = 2'd0;
          kx_d     = 2'd0;
          state_d  = ((Tile_W < 7'd3) || (Tile_H < 7'd3)) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue && last_read) state_d = StDrain;
      end
      StDrain: begin
        if (pop && ent0_q[EntW-1]) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Head entry is always ent0; ent1 only holds a second word.
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) ent0_d = new_ent;
        else                    ent1_d = new_ent;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d     = ent1_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      tile_w_q   <= 7'd0;
      tile_h_q   <= 7'd0;
      row_q      <= 7'd0;
      col_q      <= 7'd0;
      ky_q       <= 2'd0;
      kx_q       <= 2'd0;
      rd_pend_q  <= 1'b0;
      rd_tap_q   <= 4'd0;
      rd_end_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      state_q    <= state_d;
      tile_w_q   <= tile_w_d;
      tile_h_q   <= tile_h_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      rd_pend_q  <= rd_pend_d;
      rd_tap_q   <= rd_tap_d;
      rd_end_q   <= rd_end_d;
      fifo_cnt_q <= fifo_cnt_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

  assign SRAM_CSn   = ~issue;
  assign SRAM_WEn   = 4'b1111;
  assign SRAM_Addr  = issue ? rd_addr : '0;
  assign Win_Valid  = (fifo_cnt_q != 2'd0);
  assign Win_Data   = ent0_q[DATA_W-1:0];
  assign Win_Tap    = ent0_q[DATA_W+3:DATA_W];
  assign Win_Last   = Win_Valid && (Win_Tap == 4'd8);
  assign Busy       = (state_q != StIdle);
  assign Frame_Done = (state_q == StDone);

endmodule

// File: tb/tb_conv_window_fetch.sv
// Testbench for conv_window_fetch: directed frames checked against a
// loop-based window model and an SRAM content function.
module tb_conv_window_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  tile_w;
  logic [6:0]  tile_h;
  logic        sram_csn;
  logic [3:0]  sram_wen;
  logic [11:0] sram_addr;
  logic [31:0] sram_q = '0;
  logic [31:0] win_data;
  logic [3:0]  win_tap;
  logic        win_last;
  logic        win_valid;
  logic        win_ready;
  logic        busy;
  logic        frame_done;

  conv_window_fetch #(.ADDR_W(12), .DATA_W(32)) dut (
    .CLK(clk), .RST(rst), .Start(start), .Tile_W(tile_w), .Tile_H(tile_h),
    .SRAM_CSn(sram_csn), .SRAM_WEn(sram_wen), .SRAM_Addr(sram_addr), .SRAM_Q(sram_q),
    .Win_Data(win_data), .Win_Tap(win_tap), .Win_Last(win_last), .Win_Valid(win_valid),
    .Win_Ready(win_ready), .Busy(busy), .Frame_Done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int tap; } xf_t;

  int  exp_rd[$];
  xf_t exp_xf[$];
  int  addr_log[$];

  int ncyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_reads, n_xfers, n_valid, n_done;
  int first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc, start_cyc;
  int ready_mode = 0;

  int w0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int w3[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  function automatic logic [31:0] sram_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  always @(posedge clk) if (!sram_csn) sram_q <= sram_word(int'(sram_addr));

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Window model: every output position, taps row-major.
  task automatic model_frame(input int w, input int h);
    if (w < 3 || h < 3) return;
    for (int r = 0; r <= h - 3; r++)
      for (int c = 0; c <= w - 3; c++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            xf_t e;
            e.addr = (r + ky) * w + c + kx;
            e.tap  = ky * 3 + kx;
            exp_rd.push_back(e.addr);
            exp_xf.push_back(e);
          end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_xfers = 0; n_valid = 0; n_done = 0;
    first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    addr_log.delete();
  endtask

  task automatic prep(input int w, input int h, input int mode);
    ready_mode = mode;
    clear_stats();
    exp_rd.delete();
    exp_xf.delete();
    model_frame(w, h);
  endtask

  task automatic check_reset_outputs();
    logic [56:0] act, req;
    act = {sram_csn, sram_wen, sram_addr, win_valid, win_data, win_tap, win_last, busy,
           frame_done};
    req = {1'b1, 4'hF, 12'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    check(act == req, "reset_outputs", 64'(act), 64'(req));
  endtask

  // Called at posedge+1; Start is high for the cycle that follows.
  task automatic launch_and_wait(input int w, input int h, input bit again);
    int k, nx, bound;
    nx    = (w >= 3 && h >= 3) ? (w - 2) * (h - 2) * 9 : 0;
    bound = nx * 4 + 64;
    tile_w = 7'(w); tile_h = 7'(h); start = 1'b1; start_cyc = ncyc + 1;
    @(posedge clk); #1;
    start = 1'b0; tile_w = 7'd9; tile_h = 7'd2;
    if (again) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; tile_w = 7'd5; tile_h = 7'd5;
      @(posedge clk); #1 start = 1'b0;
    end
    k = 0;
    while (n_done == 0 && k < bound) begin @(posedge clk); k++; end
    check(n_done != 0, "frame_done_timeout", 64'(k), 64'(bound));
    repeat (4) @(posedge clk);
    #1;
    check(n_xfers == nx, "xfer_count", 64'(n_xfers), 64'(nx));
    check(n_done == 1, "done_count", 64'(n_done), 64'd1);
    check(exp_rd.size() == 0 && exp_xf.size() == 0, "model_drained",
          64'(exp_rd.size() + exp_xf.size()), 64'd0);
    check(busy == 1'b0, "busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input bit again);
    prep(w, h, mode);
    @(posedge clk); #1;
    launch_and_wait(w, h, again);
  endtask

  // Consumer-ready driver.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: win_ready = 1'($urandom_range(0, 1));
        2: win_ready = (first_valid_cyc >= 0) && (ncyc + 1 - first_valid_cyc >= 20);
        default: win_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  int          ra;
  xf_t         xe;
  bit          hold_vld = 1'b0;
  logic [36:0] hold_word, exp_word, act_word;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      check(sram_wen == 4'hF, "sram_wen", 64'(sram_wen), 64'hF);
      if (!sram_csn) begin
        n_reads++;
        addr_log.push_back(int'(sram_addr));
        if (exp_rd.size() == 0) begin
          check(1'b0, "unexpected_read", 64'(sram_addr), 64'd0);
        end else begin
          ra = exp_rd.pop_front();
          check(int'(sram_addr) == ra, "read_addr", 64'(sram_addr), 64'(ra));
        end
      end
      act_word = {win_last, win_tap, win_data};
      if (hold_vld)
        check(win_valid && act_word == hold_word, "stall_hold", 64'({win_valid, act_word}),
              64'({1'b1, hold_word}));
      if (win_valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = ncyc;
        check(busy == 1'b1, "busy_while_valid", 64'(busy), 64'd1);
      end
      if (win_valid && win_ready) begin
        n_xfers++;
        if (first_xfer_cyc < 0) first_xfer_cyc = ncyc;
        last_xfer_cyc = ncyc;
        if (exp_xf.size() == 0) begin
          check(1'b0, "unexpected_xfer", 64'(act_word), 64'd0);
        end else begin
          xe = exp_xf.pop_front();
          exp_word = {xe.tap == 8, 4'(xe.tap), sram_word(xe.addr)};
          check(act_word == exp_word, "xfer_word", 64'(act_word), 64'(exp_word));
        end
      end
      hold_vld  = win_valid && !win_ready;
      hold_word = act_word;
      if (frame_done) begin
        n_done++;
        done_cyc = ncyc;
        check(exp_xf.size() == 0, "done_before_last", 64'(exp_xf.size()), 64'd0);
      end
      if (ready_mode == 2 && first_valid_cyc >= 0 && ncyc == first_valid_cyc + 19)
        check(n_reads <= 2, "stall_reads", 64'(n_reads), 64'd2);
      check(n_reads - n_xfers <= 2, "outstanding", 64'(n_reads - n_xfers), 64'd2);
    end
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; tile_w = 7'd0; tile_h = 7'd0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs();

    // 4x4, always ready: 36 back-to-back transfers.
    run_frame(4, 4, 0, 1'b0);
    check(addr_log.size() == 36, "addr_log_len", 64'(addr_log.size()), 64'd36);
    for (int i = 0; i < 9; i++) begin
      check(addr_log[i] == w0[i], "win0_addr", 64'(addr_log[i]), 64'(w0[i]));
      check(addr_log[27 + i] == w3[i], "win3_addr", 64'(addr_log[27 + i]), 64'(w3[i]));
    end
    check(last_xfer_cyc - first_xfer_cyc == 35, "consecutive_xfers",
          64'(last_xfer_cyc - first_xfer_cyc), 64'd35);
    check(done_cyc == last_xfer_cyc + 1, "done_timing", 64'(done_cyc),
          64'(last_xfer_cyc + 1));
    check(first_valid_cyc > start_cyc && first_valid_cyc - start_cyc <= 3,
          "first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd3);

    // 4x4 with a 20-cycle consumer stall.
    run_frame(4, 4, 2, 1'b0);

    // Degenerate 2x5: no reads, no data, one done pulse.
    run_frame(2, 5, 0, 1'b0);
    check(n_reads == 0 && n_valid == 0, "degenerate_quiet", 64'(n_reads + n_valid), 64'd0);
    check(done_cyc == start_cyc + 1, "degenerate_done_timing", 64'(done_cyc),
          64'(start_cyc + 1));

    // Second Start during RUN must be ignored.
    run_frame(4, 4, 0, 1'b1);

    // Reset after 10 transfers, then a 3x3 frame straight away.
    prep(4, 4, 0);
    @(posedge clk); #1;
    tile_w = 7'd4; tile_h = 7'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (n_xfers < 10 && k < 200) begin @(posedge clk); k++; end
    check(n_xfers >= 10, "pre_reset_xfers", 64'(n_xfers), 64'd10);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check(n_done == 0, "no_done_on_abort", 64'(n_done), 64'd0);
    check_reset_outputs();
    prep(3, 3, 0);
    launch_and_wait(3, 3, 1'b0);
    for (int i = 0; i < 9; i++)
      check(addr_log[i] == i, "post_reset_addr", 64'(addr_log[i]), 64'(i));

    // 52x52 with random backpressure.
    run_frame(52, 52, 1, 1'b0);
    check(n_xfers == 22500, "big_frame_xfers", 64'(n_xfers), 64'd22500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
